mem_arbiter: RTL and testbench

Shares the single backing-memory request/response port between the instruction-cache and data-cache refill/writeback paths of the three-stage-memory Riscv151 pipeline. Only one request is outstanding at a time. The dcache has priority, with a starvation bound that guarantees icache forward progress. The block sits between the two caches and the external memory model, and owns request holding, response routing and ordering.

---
 rtl/mem_arb_pkg.sv | 13 +
 rtl/mem_arb_if.sv | 51 +++++
 rtl/mem_arb_priority.sv | 41 ++++
 rtl/mem_arbiter.sv | 139 +++++++++++++
 tb/tb_mem_arbiter.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared state encoding and tag constants for the memory arbiter
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_t;

    localparam logic TAG_IC = 1'b0;
    localparam logic TAG_DC = 1'b1;

endpackage

// File: rtl/mem_arb_if.sv
// rtl/mem_arb_if.sv - icache/dcache/memory request-response bundle around the arbiter
interface mem_arb_if #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 128
);

    logic              ic_req_valid;
    logic              ic_req_ready;
    logic [ADDR_W-1:0] ic_req_addr;
    logic              ic_resp_valid;
    logic [LINE_W-1:0] ic_resp_data;

    logic              dc_req_valid;
    logic              dc_req_ready;
    logic              dc_req_rw;
    logic [ADDR_W-1:0] dc_req_addr;
    logic [LINE_W-1:0] dc_req_data;
    logic              dc_resp_valid;
    logic [LINE_W-1:0] dc_resp_data;

    logic              mem_req_valid;
    logic              mem_req_ready;
    logic              mem_req_rw;
    logic [ADDR_W-1:0] mem_req_addr;
    logic [LINE_W-1:0] mem_req_data;
    logic              mem_req_tag;
    logic              mem_resp_valid;
    logic              mem_resp_tag;
    logic [LINE_W-1:0] mem_resp_data;

    // Arbiter view
    modport slave (
        input  ic_req_valid, ic_req_addr,
        output ic_req_ready, ic_resp_valid, ic_resp_data,
        input  dc_req_valid, dc_req_rw, dc_req_addr, dc_req_data,
        output dc_req_ready, dc_resp_valid, dc_resp_data,
        output mem_req_valid, mem_req_rw, mem_req_addr, mem_req_data, mem_req_tag,
        input  mem_req_ready, mem_resp_valid, mem_resp_tag, mem_resp_data
    );

    // Caches plus memory model view
    modport master (
        output ic_req_valid, ic_req_addr,
        input  ic_req_ready, ic_resp_valid, ic_resp_data,
        output dc_req_valid, dc_req_rw, dc_req_addr, dc_req_data,
        input  dc_req_ready, dc_resp_valid, dc_resp_data,
        input  mem_req_valid, mem_req_rw, mem_req_addr, mem_req_data, mem_req_tag,
        output mem_req_ready, mem_resp_valid, mem_resp_tag, mem_resp_data
    );

endinterface

// File: rtl/mem_arb_priority.sv
// rtl/mem_arb_priority.sv - dcache-first grant with a bounded icache starvation counter
module mem_arb_priority
    import mem_arb_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic arb_en,
    input  logic ic_valid,
    input  logic dc_valid,
    output logic grant_ic,
    output logic grant_dc
);

    localparam logic [3:0] MAX_CNT = 4'(MAX_WAIT);

    logic [3:0] starve_cnt;
    logic       ic_acc;
    logic       dc_acc;

    // Once icache has lost MAX_WAIT times in a row it takes the next slot
    always_comb begin
        grant_dc = dc_valid && (!ic_valid || (starve_cnt != MAX_CNT));
        grant_ic = ic_valid && !grant_dc;
    end

    assign ic_acc = arb_en && grant_ic;
    assign dc_acc = arb_en && grant_dc;

    always_ff @(posedge clk) begin
        if (!reset) begin
            starve_cnt <= 4'd0;
        end else if (ic_acc) begin
            starve_cnt <= 4'd0;
        end else if (dc_acc && ic_valid && (starve_cnt != MAX_CNT)) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-outstanding icache/dcache arbiter onto the backing memory port
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int LINE_W   = 128,
    parameter int MAX_WAIT = 4
) (
    input  logic     clk,
    input  logic     reset,
    mem_arb_if.slave bus
);

    arb_state_t        state;
    arb_state_t        state_nxt;

    logic              arb_en;
    logic              grant_ic;
    logic              grant_dc;
    logic              ic_acc;
    logic              dc_acc;
    logic              resp_hit;
    logic              req_valid;

    logic              h_rw;
    logic [ADDR_W-1:0] h_addr;
    logic [LINE_W-1:0] h_data;
    logic              h_tag;

    logic              ic_resp_valid_q;
    logic              dc_resp_valid_q;
    logic [LINE_W-1:0] ic_resp_data_q;
    logic [LINE_W-1:0] dc_resp_data_q;

    // Readies are gated by reset so nothing is accepted while reset is held
    assign arb_en = reset && (state == IDLE);
    assign ic_acc = arb_en && grant_ic;
    assign dc_acc = arb_en && grant_dc;

    mem_arb_priority #(
        .MAX_WAIT (MAX_WAIT)
    ) u_priority (
        .clk      (clk),
        .reset    (reset),
        .arb_en   (arb_en),
        .ic_valid (bus.ic_req_valid),
        .dc_valid (bus.dc_req_valid),
        .grant_ic (grant_ic),
        .grant_dc (grant_dc)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        req_valid = 1'b0;
        resp_hit  = 1'b0;
        case (state)
            IDLE: begin
                if (ic_acc || dc_acc) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                req_valid = 1'b1;
                if (bus.mem_req_ready) begin
                    state_nxt = h_rw ? IDLE : WAIT;
                end
            end
            WAIT: begin
                // Responses carrying the other requester's tag are dropped
                resp_hit = bus.mem_resp_valid && (bus.mem_resp_tag == h_tag);
                if (resp_hit) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            h_rw   <= 1'b0;
            h_addr <= '0;
            h_data <= '0;
            h_tag  <= TAG_IC;
        end else if (ic_acc) begin
            h_rw   <= 1'b0;
            h_addr <= bus.ic_req_addr;
            h_data <= '0;
            h_tag  <= TAG_IC;
        end else if (dc_acc) begin
            h_rw   <= bus.dc_req_rw;
            h_addr <= bus.dc_req_addr;
            h_data <= bus.dc_req_data;
            h_tag  <= TAG_DC;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ic_resp_valid_q <= 1'b0;
            dc_resp_valid_q <= 1'b0;
            ic_resp_data_q  <= '0;
            dc_resp_data_q  <= '0;
        end else begin
            ic_resp_valid_q <= resp_hit && (h_tag == TAG_IC);
            dc_resp_valid_q <= resp_hit && (h_tag == TAG_DC);
            if (resp_hit && (h_tag == TAG_IC)) begin
                ic_resp_data_q <= bus.mem_resp_data;
            end
            if (resp_hit && (h_tag == TAG_DC)) begin
                dc_resp_data_q <= bus.mem_resp_data;
            end
        end
    end

    assign bus.ic_req_ready  = ic_acc;
    assign bus.dc_req_ready  = dc_acc;
    assign bus.ic_resp_valid = ic_resp_valid_q;
    assign bus.ic_resp_data  = ic_resp_data_q;
    assign bus.dc_resp_valid = dc_resp_valid_q;
    assign bus.dc_resp_data  = dc_resp_data_q;

    assign bus.mem_req_valid = req_valid;
    assign bus.mem_req_rw    = h_rw;
    assign bus.mem_req_addr  = h_addr;
    assign bus.mem_req_data  = h_data;
    assign bus.mem_req_tag   = h_tag;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed and randomized checks of mem_arbiter against a transaction model
module tb_mem_arbiter;

    localparam int ADDR_W   = 32;
    localparam int LINE_W   = 128;
    localparam int MAX_WAIT = 4;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    mem_arb_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) bus ();

    mem_arbiter #(
        .ADDR_W   (ADDR_W),
        .LINE_W   (LINE_W),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Transaction-level model of the two requesters and the arbitration rule
    bit               ic_pend, dc_pend;
    logic [31:0]      ic_addr, dc_addr;
    bit               dc_rw;
    logic [127:0]     dc_data;
    int               starve;
    logic [127:0]     last_ic, last_dc;

    bit               cur_dc, cur_rw, got_dc;
    logic [31:0]      cur_addr;
    logic [127:0]     cur_data;
    bit               exp_seq [10];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] rnd_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic drive_reqs();
        bus.ic_req_valid = ic_pend;
        bus.ic_req_addr  = ic_addr;
        bus.dc_req_valid = dc_pend;
        bus.dc_req_rw    = dc_rw;
        bus.dc_req_addr  = dc_addr;
        bus.dc_req_data  = dc_data;
    endtask

    task automatic new_ic(input logic [31:0] a);
        ic_pend = 1'b1;
        ic_addr = a;
    endtask

    task automatic new_dc(input bit rw, input logic [31:0] a, input logic [127:0] d);
        dc_pend = 1'b1;
        dc_rw   = rw;
        dc_addr = a;
        dc_data = d;
    endtask

    task automatic model_reset();
        starve  = 0;
        last_ic = '0;
        last_dc = '0;
        ic_pend = 1'b0;
        dc_pend = 1'b0;
    endtask

    task automatic check_quiet(input string where);
        chk({where, "_ic_resp_valid"}, bus.ic_resp_valid, 1'b0);
        chk({where, "_dc_resp_valid"}, bus.dc_resp_valid, 1'b0);
        chk({where, "_mem_req_valid"}, bus.mem_req_valid, 1'b0);
        chk({where, "_ic_ready"}, bus.ic_req_ready, 1'b0);
        chk({where, "_dc_ready"}, bus.dc_req_ready, 1'b0);
    endtask

    // Arbiter is idle now; predict the winner, check readies, take the accept edge
    task automatic arb_step();
        bit exp_dc;
        drive_reqs();
        #1;
        exp_dc = dc_pend && (!ic_pend || starve != MAX_WAIT);
        got_dc = bus.dc_req_ready;
        chk("dc_req_ready", bus.dc_req_ready, exp_dc);
        chk("ic_req_ready", bus.ic_req_ready, !exp_dc);
        cur_dc   = exp_dc;
        cur_rw   = exp_dc ? dc_rw : 1'b0;
        cur_addr = exp_dc ? dc_addr : ic_addr;
        cur_data = exp_dc ? dc_data : '0;
        if (exp_dc) begin
            if (ic_pend && starve < MAX_WAIT) starve++;
            dc_pend = 1'b0;
        end else begin
            starve  = 0;
            ic_pend = 1'b0;
        end
        cyc();
        drive_reqs();
    endtask

    task automatic issue_step(input int delay, input bit early);
        for (int i = 0; i <= delay; i++) begin
            bus.mem_req_ready = (i == delay);
            if (i == delay && early && !cur_rw) begin
                bus.mem_resp_valid = 1'b1;
                bus.mem_resp_tag   = cur_dc;
                bus.mem_resp_data  = rnd_line();
            end
            #1;
            chk("mem_req_valid", bus.mem_req_valid, 1'b1);
            chk("mem_req_tag", bus.mem_req_tag, cur_dc);
            chk("mem_req_rw", bus.mem_req_rw, cur_rw);
            chk("mem_req_addr", bus.mem_req_addr, cur_addr);
            if (cur_dc) chk("mem_req_data", bus.mem_req_data, cur_data);
            chk("issue_ic_ready", bus.ic_req_ready, 1'b0);
            chk("issue_dc_ready", bus.dc_req_ready, 1'b0);
            cyc();
        end
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        if (cur_rw) begin
            #1;
            chk("wr_done_mem_req_valid", bus.mem_req_valid, 1'b0);
            chk("wr_done_ic_resp_valid", bus.ic_resp_valid, 1'b0);
            chk("wr_done_dc_resp_valid", bus.dc_resp_valid, 1'b0);
        end
    endtask

    task automatic resp_step(input int delay, input bit bad, input logic [127:0] rdata);
        for (int i = 0; i < delay; i++) begin
            #1;
            check_quiet("wait");
            cyc();
        end
        if (bad) begin
            bus.mem_resp_valid = 1'b1;
            bus.mem_resp_tag   = !cur_dc;
            bus.mem_resp_data  = rnd_line();
            #1;
            check_quiet("bad");
            cyc();
        end
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_tag   = cur_dc;
        bus.mem_resp_data  = rdata;
        #1;
        check_quiet("resp");
        cyc();
        bus.mem_resp_valid = 1'b0;
        #1;
        chk("pulse_mem_req_valid", bus.mem_req_valid, 1'b0);
        if (cur_dc) begin
            chk("dc_resp_valid", bus.dc_resp_valid, 1'b1);
            chk("dc_resp_data", bus.dc_resp_data, rdata);
            chk("ic_resp_valid_other", bus.ic_resp_valid, 1'b0);
            chk("ic_resp_data_hold", bus.ic_resp_data, last_ic);
            last_dc = rdata;
        end else begin
            chk("ic_resp_valid", bus.ic_resp_valid, 1'b1);
            chk("ic_resp_data", bus.ic_resp_data, rdata);
            chk("dc_resp_valid_other", bus.dc_resp_valid, 1'b0);
            chk("dc_resp_data_hold", bus.dc_resp_data, last_dc);
            last_ic = rdata;
        end
    endtask

    task automatic service(input int d, input bit early, input int rd, input bit bad);
        issue_step(d, early);
        if (!cur_rw) resp_step(rd, bad, rnd_line());
    endtask

    initial begin
        exp_seq = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
        model_reset();
        ic_addr = '0; dc_addr = '0; dc_rw = 1'b0; dc_data = '0;
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_tag   = 1'b0;
        bus.mem_resp_data  = '0;

        // Reset with both requesters valid
        reset = 1'b0;
        bus.ic_req_valid = 1'b1; bus.ic_req_addr = 32'h100;
        bus.dc_req_valid = 1'b1; bus.dc_req_rw = 1'b0; bus.dc_req_addr = 32'h200; bus.dc_req_data = '0;
        cyc();
        cyc();
        #1;
        check_quiet("reset");
        chk("reset_mem_req_addr", bus.mem_req_addr, 32'h0);
        chk("reset_ic_resp_data", bus.ic_resp_data, 128'h0);
        cyc();
        reset = 1'b1;
        #1;
        chk("post_reset_dc_ready", bus.dc_req_ready, 1'b1);
        chk("post_reset_ic_ready", bus.ic_req_ready, 1'b0);
        bus.ic_req_valid = 1'b0;
        bus.dc_req_valid = 1'b0;
        cyc();
        #1;
        chk("dropped_mem_req_valid", bus.mem_req_valid, 1'b0);

        // Single icache read
        new_ic(32'h0000_1000);
        arb_step();
        issue_step(0, 0);
        resp_step(0, 0, {16{8'hA5}});
        cyc();
        chk("ic_pulse_once", bus.ic_resp_valid, 1'b0);

        // dcache write with memory stalling
        new_dc(1'b1, 32'h40, rnd_line());
        arb_step();
        issue_step(3, 0);

        // Both continuously valid: grant pattern
        new_ic(32'h2000);
        new_dc(1'b1, 32'h3000, rnd_line());
        for (int i = 0; i < 10; i++) begin
            arb_step();
            chk($sformatf("grant_seq_%0d", i), got_dc, exp_seq[i]);
            service(0, 0, 0, 0);
            if (cur_dc) new_dc(1'b1, 32'h3000 + 32'(i) * 16, rnd_line());
            else        new_ic(32'h2000 + 32'(i) * 16);
        end
        ic_pend = 1'b0; dc_pend = 1'b0;
        drive_reqs();

        // dcache read with a foreign-tag response first
        new_dc(1'b0, 32'h80, rnd_line());
        arb_step();
        issue_step(0, 0);
        resp_step(0, 1, rnd_line());

        // Reset in WAIT, then a late response
        new_dc(1'b0, 32'hC0, rnd_line());
        arb_step();
        issue_step(1, 0);
        reset = 1'b0;
        #1;
        chk("rst_wait_dc_ready", bus.dc_req_ready, 1'b0);
        cyc();
        reset = 1'b1;
        model_reset();
        drive_reqs();
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_tag   = 1'b1;
        bus.mem_resp_data  = rnd_line();
        #1;
        chk("late_mem_req_valid", bus.mem_req_valid, 1'b0);
        chk("late_mem_req_addr", bus.mem_req_addr, 32'h0);
        cyc();
        bus.mem_resp_valid = 1'b0;
        #1;
        chk("late_dc_resp_valid", bus.dc_resp_valid, 1'b0);
        chk("late_ic_resp_valid", bus.ic_resp_valid, 1'b0);
        new_ic(32'h4000);
        arb_step();
        service(0, 0, 1, 0);

        // Randomized traffic
        for (int t = 0; t < 60; t++) begin
            if (!ic_pend && ($urandom % 2 == 0)) new_ic($urandom & 32'hFFFF_FFF0);
            if (!dc_pend && ($urandom % 2 == 0)) new_dc($urandom % 2 == 0, $urandom & 32'hFFFF_FFF0, rnd_line());
            if (!ic_pend && !dc_pend) new_dc($urandom % 2 == 0, $urandom & 32'hFFFF_FFF0, rnd_line());
            arb_step();
            service($urandom_range(0, 3), $urandom % 4 == 0, $urandom_range(0, 2), $urandom % 3 == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
